// File: rtl/bla_sub_seq.sv
// bla_sub_seq: sequential borrow-lookahead subtractor, D = A - B - Bin.
// One 4-bit lookahead group is processed per clock, LSB group first.
// Optional feature macro: SUB_OVF_EN adds the signed-overflow output ovf.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | processing group k from latched operands and registered borrow
// DONE  | result held on d/bout(/ovf), out_valid=1 until out_ready

module bla_sub_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NGROUPS = WIDTH / 4;
    localparam int KW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state, state_next;
    logic [WIDTH-1:0]  a_q, b_q, d_q;
    logic              brw_q, bout_q;
    logic [KW-1:0]     k;
    logic [3:0]        ga, gb, g, p, diff;
    logic [4:0]        c;
    logic              last_grp, accept;

    assign accept   = in_valid && (state == IDLE);
    assign last_grp = (k == KW'(NGROUPS - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (last_grp) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Group k lookahead: all four in-group borrows come straight from g/p
    // and the registered group borrow, not from each other.
    always_comb begin
        ga   = a_q[{k, 2'b00} +: 4];
        gb   = b_q[{k, 2'b00} +: 4];
        g    = ~ga & gb;
        p    = ~(ga ^ gb);
        c[0] = brw_q;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        diff = ga ^ gb ^ c[3:0];
    end

    // Operand latch, per-group result write and final borrow capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            d_q    <= '0;
            brw_q  <= 1'b0;
            bout_q <= 1'b0;
            k      <= '0;
        end else if (accept) begin
            a_q    <= a;
            b_q    <= b;
            d_q    <= '0;
            brw_q  <= bin;
            bout_q <= 1'b0;
            k      <= '0;
        end else if (state == RUN) begin
            d_q[{k, 2'b00} +: 4] <= diff;
            brw_q <= c[4];
            k     <= k + KW'(1);
            if (last_grp) bout_q <= c[4];
        end
    end

`ifdef SUB_OVF_EN
    logic ovf_q;

    // Signed overflow from latched operand signs and the final group's MSB
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          ovf_q <= 1'b0;
        else if (accept)                  ovf_q <= 1'b0;
        else if (state == RUN && last_grp)
            ovf_q <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[3] != a_q[WIDTH-1]);
    end

    assign ovf = ovf_q;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign d         = d_q;
    assign bout      = bout_q;

endmodule

// File: tb/tb_bla_sub_seq.sv
// Testbench for bla_sub_seq at WIDTH=16: directed cases plus random operands
// compared against an arithmetic reference model.

module tb_bla_sub_seq;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             bin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] d;
    logic             bout;
`ifdef SUB_OVF_EN
    logic             ovf;
`endif

    int checks = 0;
    int errors = 0;

    bla_sub_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout)
`ifdef SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction: accept, exact 4-cycle latency, hold for 'hold'
    // cycles under backpressure with in_valid driven, then release.
    task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                         input logic tbin, input int hold, input string tag);
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] exp_d;
        logic             exp_bout;
        full     = {1'b0, ta} - {1'b0, tb} - {{WIDTH{1'b0}}, tbin};
        exp_d    = full[WIDTH-1:0];
        exp_bout = ({1'b0, ta} < ({1'b0, tb} + {{WIDTH{1'b0}}, tbin}));

        @(negedge clk);
        chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        a = ta; b = tb; bin = tbin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom);
        for (int j = 1; j <= 4; j++) begin
            @(posedge clk); #1;
            if (j < 4) chk({tag, "_lat_ov"}, 32'(out_valid), 32'd0);
        end
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
        chk({tag, "_d"}, 32'(d), 32'(exp_d));
        chk({tag, "_bout"}, 32'(bout), 32'(exp_bout));
`ifdef SUB_OVF_EN
        chk({tag, "_ovf"}, 32'(ovf),
            32'((ta[WIDTH-1] != tb[WIDTH-1]) && (exp_d[WIDTH-1] != ta[WIDTH-1])));
`endif
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            in_valid = 1'b1; a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
            @(posedge clk); #1;
            chk({tag, "_hold_ov"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_ir"}, 32'(in_ready), 32'd0);
            chk({tag, "_hold_d"}, 32'(d), 32'(exp_d));
            chk({tag, "_hold_bout"}, 32'(bout), 32'(exp_bout));
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_rel_ov"}, 32'(out_valid), 32'd0);
        chk({tag, "_rel_ir"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [WIDTH-1:0] da [7];
        logic [WIDTH-1:0] db [7];
        logic             dbin [7];
        da = '{16'h1234, 16'h1000, 16'h0000, 16'h00FF, 16'h8000, 16'h7FFF, 16'hFFFF};
        db = '{16'h0234, 16'h0001, 16'h0001, 16'h00FF, 16'h0001, 16'h0001, 16'hFFFF};
        dbin = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_d", 32'(d), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
`ifdef SUB_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // out_ready while idle has no effect
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("idle_oready_ir", 32'(in_ready), 32'd1);
        chk("idle_oready_ov", 32'(out_valid), 32'd0);

        for (int i = 0; i < 7; i++)
            do_op(da[i], db[i], dbin[i], (i == 0) ? 5 : 0, $sformatf("dir%0d", i));

        // Reset after the second RUN edge discards the operation
        @(negedge clk);
        a = 16'hABCD; b = 16'h1234; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_ov", 32'(out_valid), 32'd0);
        chk("midrst_ir", 32'(in_ready), 32'd1);
        chk("midrst_d", 32'(d), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op(16'h0005, 16'h0003, 1'b0, 0, "post_rst");

        for (int r = 0; r < 25; r++)
            do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                  $sformatf("rnd%0d", r));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
